lsu_mem_master: RTL and testbench

- Core-side load/store initiator for the shared word-wide unified memory; drives the data port of the memory bus.
- Accepts RV32I byte/half/word load and store requests over a valid/ready handshake.
- Issues only aligned 32-bit word accesses to memory. Sub-word stores are performed as read-modify-write.
- Returns load data sign- or zero-extended and flags misaligned or out-of-range accesses.
- Sits between the execute stage of riscv_32i and the memory data port. The memory port has combinational read and writes on the clock edge.

---
 rtl/lsu_mem_master.sv | 160 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-wide unified memory: byte/half/word RV32I
// accesses mapped onto aligned word reads/writes, sub-word stores via read-modify-write.
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 131072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state;
  logic        we_q;
  logic        err_q;
  logic        wr_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        req_err_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;
  logic [31:0] merge_c;

  // Reset gates these directly so an aborted WRITE never reaches memory.
  assign req_ready = (state == IDLE) && reset;
  assign mem_we    = wr_q && reset;

  // Request legality: funct3 vs direction, alignment, address range.
  always_comb begin
    req_err_c = 1'b0;
    if (req_we) begin
      if (req_funct3 != F3_B && req_funct3 != F3_H && req_funct3 != F3_W)
        req_err_c = 1'b1;
    end else begin
      if (req_funct3 != F3_B && req_funct3 != F3_H && req_funct3 != F3_W &&
          req_funct3 != F3_BU && req_funct3 != F3_HU)
        req_err_c = 1'b1;
    end
    if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
      req_err_c = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
      req_err_c = 1'b1;
    if (32'(req_addr[31:2]) >= MEM_WORDS)
      req_err_c = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_c  = mem_rdata[{lane_q, 3'b000} +: 8];
    half_c  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_c  = mem_rdata;
    merge_c = mem_rdata;
    case (funct3_q)
      F3_B:    load_c = {{24{byte_c[7]}}, byte_c};
      F3_BU:   load_c = {24'd0, byte_c};
      F3_H:    load_c = {{16{half_c[15]}}, half_c};
      F3_HU:   load_c = {16'd0, half_c};
      default: load_c = mem_rdata;
    endcase
    if (funct3_q == F3_B)
      merge_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else if (lane_q[1])
      merge_c[31:16] = wdata_q;
    else
      merge_c[15:0] = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      wr_q       <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      funct3_q   <= 3'd0;
      lane_q     <= 2'd0;
      wdata_q    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            lane_q   <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            err_q    <= req_err_c;
            // Errors still pass through READ so every non-RMW request has equal latency.
            if (req_err_c) begin
              state <= READ;
            end else if (req_we && req_funct3 == F3_W) begin
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= req_wdata;
              wr_q      <= 1'b1;
              state     <= WRITE;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              state    <= READ;
            end
          end
        end
        READ: begin
          if (err_q) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= 32'd0;
            state      <= RESP;
          end else if (!we_q) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_c;
            state      <= RESP;
          end else begin
            mem_wdata <= merge_c;
            wr_q      <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          wr_q       <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a small word memory model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [31:0] pre_data = 32'd0;

  int nvec = 0;
  int nmis = 0;

  logic [31:0] r_rdata;
  logic        r_err;
  int          r_lat;
  int          r_wcnt;
  int          r_wfirst;
  logic [31:0] r_wd;

  lsu_mem_master #(.MEM_WORDS(131072)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    pre_we = 1'b1; pre_idx = idx; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Drive one request from IDLE and record latency, write activity and response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    r_lat = 1; r_wcnt = 0; r_wfirst = 0; r_wd = 32'd0;
    while (!resp_valid && r_lat < 10) begin
      if (mem_we) begin
        r_wcnt++; r_wd = mem_wdata;
        if (r_wfirst == 0) r_wfirst = r_lat;
      end
      @(posedge clk); #1;
      r_lat++;
    end
    r_rdata = resp_rdata;
    r_err   = resp_err;
    if (mem_we) r_wcnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (resp_valid !== 1'b0) begin nmis++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    nvec++; if (resp_rdata !== 32'd0) begin nmis++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
    nvec++; if (resp_err !== 1'b0) begin nmis++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
    nvec++; if (mem_addr !== 32'd0) begin nmis++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    nvec++; if (mem_wdata !== 32'd0) begin nmis++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    nvec++; if (req_ready !== 1'b0) begin nmis++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    nvec++; if (mem_we !== 1'b0) begin nmis++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    reset = 1'b1;
    @(posedge clk); #1;
    nvec++; if (req_ready !== 1'b1) begin nmis++; $display("FAIL reset_release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_loads();
    logic [31:0] a_t [4];
    logic [2:0]  f_t [4];
    logic [31:0] e_t [4];
    preload(10'h040, 32'h8899_AABB);
    preload(10'h3FF, 32'h1357_9BDF);
    a_t = '{32'h101, 32'h103, 32'h102, 32'h100};
    f_t = '{3'b000, 3'b100, 3'b001, 3'b101};
    e_t = '{32'hFFFF_FFAA, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f_t[i], a_t[i], 32'd0);
      nvec++; if (r_rdata !== e_t[i]) begin nmis++; $display("FAIL load%0d_rdata got %h exp %h", i, r_rdata, e_t[i]); end
      nvec++; if (r_err !== 1'b0) begin nmis++; $display("FAIL load%0d_err got %b exp 0", i, r_err); end
      nvec++; if (r_lat != 2) begin nmis++; $display("FAIL load%0d_latency got %0d exp 2", i, r_lat); end
      nvec++; if (r_wcnt != 0) begin nmis++; $display("FAIL load%0d_mem_we got %0d pulses exp 0", i, r_wcnt); end
    end
    // Last in-range word.
    issue(1'b0, 3'b010, 32'h0007_FFFC, 32'd0);
    nvec++; if (r_rdata !== 32'h1357_9BDF || r_err !== 1'b0) begin nmis++; $display("FAIL lw_top_word got %h/%b exp 13579bdf/0", r_rdata, r_err); end
  endtask

  task automatic test_sub_word_store();
    issue(1'b1, 3'b000, 32'h102, 32'h1234_5677);
    nvec++; if (r_wcnt != 1) begin nmis++; $display("FAIL sb_we_pulses got %0d exp 1", r_wcnt); end
    nvec++; if (r_wd !== 32'h8877_AABB) begin nmis++; $display("FAIL sb_mem_wdata got %h exp 8877aabb", r_wd); end
    nvec++; if (r_lat != 3) begin nmis++; $display("FAIL sb_latency got %0d exp 3", r_lat); end
    nvec++; if (r_wfirst != 2) begin nmis++; $display("FAIL sb_we_cycle got %0d exp 2", r_wfirst); end
    issue(1'b0, 3'b010, 32'h100, 32'd0);
    nvec++; if (r_rdata !== 32'h8877_AABB) begin nmis++; $display("FAIL sb_readback got %h exp 8877aabb", r_rdata); end
  endtask

  task automatic test_half_and_word_store();
    issue(1'b1, 3'b001, 32'h100, 32'hDEAD_CAFE);
    nvec++; if (r_wd !== 32'h8877_CAFE) begin nmis++; $display("FAIL sh_mem_wdata got %h exp 8877cafe", r_wd); end
    nvec++; if (r_lat != 3) begin nmis++; $display("FAIL sh_latency got %0d exp 3", r_lat); end
    nvec++; if (mem[10'h040] !== 32'h8877_CAFE) begin nmis++; $display("FAIL sh_memory got %h exp 8877cafe", mem[10'h040]); end
    issue(1'b1, 3'b010, 32'h104, 32'h0102_0304);
    nvec++; if (r_wfirst != 1) begin nmis++; $display("FAIL sw_we_cycle got %0d exp 1", r_wfirst); end
    nvec++; if (r_wcnt != 1) begin nmis++; $display("FAIL sw_we_pulses got %0d exp 1", r_wcnt); end
    nvec++; if (r_lat != 2) begin nmis++; $display("FAIL sw_latency got %0d exp 2", r_lat); end
    nvec++; if (mem[10'h041] !== 32'h0102_0304) begin nmis++; $display("FAIL sw_memory got %h exp 01020304", mem[10'h041]); end
  endtask

  task automatic test_errors();
    logic        w_t [4];
    logic [2:0]  f_t [4];
    logic [31:0] a_t [4];
    w_t = '{1'b0, 1'b0, 1'b1, 1'b0};
    f_t = '{3'b010, 3'b001, 3'b100, 3'b010};
    a_t = '{32'h102, 32'h101, 32'h100, 32'h0008_0000};
    for (int i = 0; i < 4; i++) begin
      issue(w_t[i], f_t[i], a_t[i], 32'h5555_5555);
      nvec++; if (r_err !== 1'b1) begin nmis++; $display("FAIL err%0d_flag got %b exp 1", i, r_err); end
      nvec++; if (r_rdata !== 32'd0) begin nmis++; $display("FAIL err%0d_rdata got %h exp 0", i, r_rdata); end
      nvec++; if (r_lat != 2) begin nmis++; $display("FAIL err%0d_latency got %0d exp 2", i, r_lat); end
      nvec++; if (r_wcnt != 0) begin nmis++; $display("FAIL err%0d_mem_we got %0d pulses exp 0", i, r_wcnt); end
    end
    nvec++; if (mem[10'h040] !== 32'h8877_CAFE) begin nmis++; $display("FAIL err_memory got %h exp 8877cafe", mem[10'h040]); end
  endtask

  task automatic test_reset_abort();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    nvec++; if (mem_we !== 1'b0) begin nmis++; $display("FAIL abort_read_we got %b exp 0", mem_we); end
    @(posedge clk); #1;
    nvec++; if (mem_we !== 1'b1) begin nmis++; $display("FAIL abort_write_reached got %b exp 1", mem_we); end
    reset = 1'b0;
    #1;
    nvec++; if (mem_we !== 1'b0) begin nmis++; $display("FAIL abort_we_gated got %b exp 0", mem_we); end
    nvec++; if (req_ready !== 1'b0) begin nmis++; $display("FAIL abort_ready_in_reset got %b exp 0", req_ready); end
    @(posedge clk); #1;
    nvec++; if (resp_valid !== 1'b0) begin nmis++; $display("FAIL abort_resp_valid got %b exp 0", resp_valid); end
    nvec++; if (req_ready !== 1'b0) begin nmis++; $display("FAIL abort_ready_held got %b exp 0", req_ready); end
    reset = 1'b1;
    #1;
    nvec++; if (req_ready !== 1'b1) begin nmis++; $display("FAIL abort_ready_release got %b exp 1", req_ready); end
    nvec++; if (mem[10'h040] !== 32'h8877_CAFE) begin nmis++; $display("FAIL abort_memory got %h exp 8877cafe", mem[10'h040]); end
    issue(1'b0, 3'b010, 32'h100, 32'd0);
    nvec++; if (r_rdata !== 32'h8877_CAFE || r_lat != 2) begin nmis++; $display("FAIL abort_lw got %h lat %0d exp 8877cafe lat 2", r_rdata, r_lat); end
  endtask

  task automatic test_back_to_back();
    logic        w_t [4];
    logic [2:0]  f_t [4];
    logic [31:0] a_t [4];
    logic [31:0] d_t [4];
    logic [31:0] e_t [4];
    int acc = 0, rsp = 0, cyc = 0, bad = 0;
    logic rdy, prev_v;
    w_t = '{1'b0, 1'b1, 1'b0, 1'b1};
    f_t = '{3'b010, 3'b010, 3'b010, 3'b000};
    a_t = '{32'h104, 32'h108, 32'h108, 32'h104};
    d_t = '{32'd0, 32'hA5A5_A5A5, 32'd0, 32'h0000_00EE};
    e_t = '{32'h0102_0304, 32'd0, 32'hA5A5_A5A5, 32'd0};
    prev_v = 1'b0;
    req_valid = 1'b1; req_we = w_t[0]; req_funct3 = f_t[0]; req_addr = a_t[0]; req_wdata = d_t[0];
    while (rsp < 4 && cyc < 80) begin
      rdy = req_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        if (req_ready) bad++;
        acc++;
        if (acc < 4) begin
          req_we = w_t[acc]; req_funct3 = f_t[acc]; req_addr = a_t[acc]; req_wdata = d_t[acc];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (resp_valid && (req_ready || prev_v)) bad++;
      if (resp_valid) begin
        nvec++;
        if (resp_rdata !== e_t[rsp] || resp_err !== 1'b0) begin
          nmis++; $display("FAIL b2b_resp%0d got %h/%b exp %h/0", rsp, resp_rdata, resp_err, e_t[rsp]);
        end
        rsp++;
      end
      prev_v = resp_valid;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    nvec++; if (rsp != 4 || acc != 4) begin nmis++; $display("FAIL b2b_counts got acc %0d resp %0d exp 4/4", acc, rsp); end
    nvec++; if (bad != 0) begin nmis++; $display("FAIL b2b_handshake got %0d violations exp 0", bad); end
    nvec++; if (mem[10'h041] !== 32'h0102_03EE) begin nmis++; $display("FAIL b2b_memory got %h exp 010203ee", mem[10'h041]); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sub_word_store();
    test_half_and_word_store();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
